// File: rtl/window_gen_3x3_pkg.sv
// -----------------------------------------------------------------------------
// window_gen_3x3_pkg
//   Shared constants for the 3x3 sliding-window generator:
//     - DATA_W_DEF : default signed pixel width
//     - WIN_*      : row-major window slot indices, WIN_TL = (r-2,c-2) ..
//                    WIN_BR = (r,c)
//     - win_idx()  : (window row, window column) -> slot index
// -----------------------------------------------------------------------------
package window_gen_3x3_pkg;

    localparam int DATA_W_DEF = 8;

    localparam int WIN_DIM = 3;
    localparam int WIN_N   = WIN_DIM * WIN_DIM;

    // Window slots, row-major. Top row is the oldest image row (r-2).
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    function automatic int win_idx(input int r, input int c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
//   One image row of storage. Read is combinational at the same address that
//   is written, so rdata shows the value stored *before* this cycle's write;
//   that old value is what cascades into the next (older) line buffer.
//
//   Ports:
//     clk   : clock, write on rising edge
//     we    : write enable
//     addr  : column address (0..DEPTH-1)
//     wdata : data written at addr when we
//     rdata : current content at addr (pre-write)
//
//   Storage is intentionally not reset; the window generator never exposes a
//   column/row that has not been written in the current frame.
// -----------------------------------------------------------------------------
module line_buffer #(
    parameter  int DEPTH  = 28,
    parameter  int DATA_W = 8,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//   Converts a raster-order pixel stream into 3x3 "valid" convolution windows
//   (no padding). One window per pixel at (row>=2, col>=2), presented one
//   cycle after that pixel is accepted, through a single-entry output stage.
//
//   Ports:
//     clk, rst          : clock; synchronous active-high reset
//     in_valid/in_data  : raster pixel stream (signed DATA_W)
//     in_ready          : pixel accepted when in_valid && in_ready
//     out_valid         : window on win0..win8 is valid
//     out_ready         : downstream consumes the window
//     win0..win8        : row-major window, win0 = (r-2,c-2), win8 = (r,c)
//     out_last          : final window of the frame (qualified by out_valid)
// -----------------------------------------------------------------------------
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] win0,
    output logic signed [DATA_W-1:0] win1,
    output logic signed [DATA_W-1:0] win2,
    output logic signed [DATA_W-1:0] win3,
    output logic signed [DATA_W-1:0] win4,
    output logic signed [DATA_W-1:0] win5,
    output logic signed [DATA_W-1:0] win6,
    output logic signed [DATA_W-1:0] win7,
    output logic signed [DATA_W-1:0] win8,
    output logic                     out_last
);

    localparam int NUM_LB = 2;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic accept;
    logic produce;
    logic col_end;
    logic frame_end;

    // lb_rdata[0] = row r-1 at col, lb_rdata[1] = row r-2 at col
    logic [NUM_LB-1:0][DATA_W-1:0] lb_wdata;
    logic [NUM_LB-1:0][DATA_W-1:0] lb_rdata;

    logic [WIN_N-1:0][DATA_W-1:0] win_q;
    logic [WIN_N-1:0][DATA_W-1:0] win_nxt;

    // -------------------------------------------------------------------------
    // Handshake. in_ready depends only on registered state and out_ready, so
    // there is no combinational path from in_valid.
    // -------------------------------------------------------------------------
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign col_end   = (col == COL_LAST);
    assign frame_end = col_end && (row == ROW_LAST);

    // Only positions with two full rows/columns of history form a window;
    // this also masks stale line-buffer data left over from the previous
    // row or frame.
    assign produce = accept && (row > ROW_W'(1)) && (col > COL_W'(1));

    // -------------------------------------------------------------------------
    // Line buffers, cascaded: each accepted pixel goes into LB0 at col, and
    // LB0's previous content at col is pushed into LB1 at col.
    // -------------------------------------------------------------------------
    assign lb_wdata[0] = in_data;
    assign lb_wdata[1] = lb_rdata[0];

    for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
        line_buffer #(
            .DEPTH (IMG_W),
            .DATA_W(DATA_W)
        ) u_lb (
            .clk  (clk),
            .we   (accept),
            .addr (col),
            .wdata(lb_wdata[i]),
            .rdata(lb_rdata[i])
        );
    end

    // -------------------------------------------------------------------------
    // Window shift: every window row moves one column left and the new right
    // column is {r-2, r-1, r} at the current col.
    // -------------------------------------------------------------------------
    always_comb begin
        win_nxt = win_q;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM - 1; c++) begin
                win_nxt[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
            end
        end
        win_nxt[WIN_TR] = lb_rdata[1];
        win_nxt[WIN_MR] = lb_rdata[0];
        win_nxt[WIN_BR] = in_data;
    end

    // -------------------------------------------------------------------------
    // Counters, window register and output stage.
    // The window register only moves on accept, and accept while out_valid
    // implies out_ready, so a held window can never be disturbed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                win_q <= win_nxt;
                if (col_end) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            // New window wins over a same-cycle consume; otherwise a consume
            // empties the stage.
            if (produce) begin
                out_valid <= 1'b1;
                out_last  <= frame_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign win0 = win_q[WIN_TL];
    assign win1 = win_q[WIN_TC];
    assign win2 = win_q[WIN_TR];
    assign win3 = win_q[WIN_ML];
    assign win4 = win_q[WIN_MC];
    assign win5 = win_q[WIN_MR];
    assign win6 = win_q[WIN_BL];
    assign win7 = win_q[WIN_BC];
    assign win8 = win_q[WIN_BR];

endmodule

// File: tb/tb_window_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3
//   Randomised stimulus against a raster-image model: the model stores every
//   accepted pixel in a 2-D image and, for each pixel at (r>=2, c>=2), slices
//   the 3x3 neighbourhood out of that image into an expected-window queue.
//   A negedge process checks handshake, latency, content and out_last every
//   cycle; literal windows pin the model for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_window_gen_3x3;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic signed [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;

    always #5 clk = ~clk;

    window_gen_3x3 #(
        .IMG_W (W),
        .IMG_H (H),
        .DATA_W(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .win0     (win0),
        .win1     (win1),
        .win2     (win2),
        .win3     (win3),
        .win4     (win4),
        .win5     (win5),
        .win6     (win6),
        .win7     (win7),
        .win8     (win8),
        .out_last (out_last)
    );

    typedef struct packed {
        logic               last;
        logic [8:0][DW-1:0] w;
    } win_t;

    logic [8:0][DW-1:0] dut_w;
    assign dut_w = {win8, win7, win6, win5, win4, win3, win2, win1, win0};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic win_t lit(input int a0, input int a1, input int a2,
                                 input int a3, input int a4, input int a5,
                                 input int a6, input int a7, input int a8,
                                 input bit l);
        win_t r;
        r.last = l;
        r.w = {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4),
               DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
        return r;
    endfunction

    // ---------------------------------------------------------------- model
    logic [DW-1:0] img [H][W];
    int            mr = 0, mc = 0;
    win_t          exp_q[$];
    win_t          log_q[$];
    win_t          e_nx;
    int            nlast = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mr = 0;
            mc = 0;
        end else begin
            check("in_ready", 80'(in_ready), 80'(!out_valid || out_ready));
            check("out_valid", 80'(out_valid), 80'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                check("window", 80'(dut_w), 80'(exp_q[0].w));
                check("out_last", 80'(out_last), 80'(exp_q[0].last));
                if (out_ready) begin
                    if (exp_q[0].last) nlast++;
                    log_q.push_back(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                img[mr][mc] = in_data;
                if (mr >= 2 && mc >= 2) begin
                    for (int k = 0; k < 9; k++)
                        e_nx.w[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
                    e_nx.last = (mr == H - 1) && (mc == W - 1);
                    exp_q.push_back(e_nx);
                end
                if (mc == W - 1) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
        end
    end

    // ---------------------------------------------------------------- driver
    bit acc;
    int stall_left = 0;
    bit rnd_ready  = 1'b0;

    // One clock: sample acceptance before the edge, update out_ready after it.
    task automatic tick();
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            out_ready  = 1'b0;
            stall_left--;
        end else begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic send(input logic [DW-1:0] p, input int gap_pct, input bit stall);
        int n;
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = p;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: pixel %0d not accepted in %0d cycles", p, n);
        end
        in_valid = 1'b0;
        if (stall) begin
            // This cycle plus four more from tick(): five cycles of backpressure.
            out_ready  = 1'b0;
            stall_left = 4;
        end
    endtask

    task automatic frame(input int base, input int gap_pct, input int stall_idx);
        for (int i = 0; i < W * H; i++)
            send(DW'(base + i), gap_pct, i == stall_idx);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d windows still pending", exp_q.size());
        end
        tick();
        tick();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    int s, l;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_out_last", 80'(out_last), 80'(0));
        check("rst_in_ready", 80'(in_ready), 80'(1));
        check("rst_window", 80'(dut_w), 80'(0));

        // continuous frame, always ready
        s = log_q.size(); l = nlast;
        frame(0, 0, -1);
        drain();
        check("t1_count", 80'(log_q.size() - s), 80'(4));
        check("t1_first", 80'(log_q[s]),   80'(lit(0, 1, 2, 4, 5, 6, 8, 9, 10, 0)));
        check("t1_second", 80'(log_q[s+1]), 80'(lit(1, 2, 3, 5, 6, 7, 9, 10, 11, 0)));
        check("t1_last", 80'(log_q[s+3]),  80'(lit(5, 6, 7, 9, 10, 11, 13, 14, 15, 1)));
        check("t1_nlast", 80'(nlast - l), 80'(1));

        // backpressure for 5 cycles right after pixel 10
        s = log_q.size();
        frame(0, 0, 10);
        drain();
        check("t2_count", 80'(log_q.size() - s), 80'(4));
        check("t2_first", 80'(log_q[s]),  80'(lit(0, 1, 2, 4, 5, 6, 8, 9, 10, 0)));
        check("t2_last", 80'(log_q[s+3]), 80'(lit(5, 6, 7, 9, 10, 11, 13, 14, 15, 1)));

        // 50% input gaps
        s = log_q.size();
        frame(0, 50, -1);
        drain();
        check("t3_count", 80'(log_q.size() - s), 80'(4));
        check("t3_third", 80'(log_q[s+2]), 80'(lit(4, 5, 6, 8, 9, 10, 12, 13, 14, 0)));
        check("t3_last", 80'(log_q[s+3]),  80'(lit(5, 6, 7, 9, 10, 11, 13, 14, 15, 1)));

        // two frames back-to-back
        s = log_q.size(); l = nlast;
        frame(0, 0, -1);
        frame(100, 0, -1);
        drain();
        check("t4_count", 80'(log_q.size() - s), 80'(8));
        check("t4_f2_first", 80'(log_q[s+4]),
              80'(lit(100, 101, 102, 104, 105, 106, 108, 109, 110, 0)));
        check("t4_nlast", 80'(nlast - l), 80'(2));

        // reset mid-frame after pixel 9
        s = log_q.size();
        for (int i = 0; i < 10; i++) send(DW'(i), 0, 1'b0);
        do_reset();
        check("t5_no_win", 80'(log_q.size() - s), 80'(0));
        check("t5_rst_valid", 80'(out_valid), 80'(0));
        frame(0, 0, -1);
        drain();
        check("t5_count", 80'(log_q.size() - s), 80'(4));
        check("t5_first", 80'(log_q[s]),  80'(lit(0, 1, 2, 4, 5, 6, 8, 9, 10, 0)));
        check("t5_last", 80'(log_q[s+3]), 80'(lit(5, 6, 7, 9, 10, 11, 13, 14, 15, 1)));

        // signed extremes, random ready
        rnd_ready = 1'b1;
        s = log_q.size();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < W * H; i++)
                send(((i + f) % 2 == 0) ? 8'h80 : 8'h7f, 30, 1'b0);
        drain();
        check("t6_count", 80'(log_q.size() - s), 80'(8));
        check("t6_first", 80'(log_q[s]),
              80'(lit(-128, 127, -128, -128, 127, -128, -128, 127, -128, 0)));

        // random data, gaps and backpressure
        s = log_q.size(); l = nlast;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < W * H; i++)
                send(DW'($urandom), 30, 1'b0);
        drain();
        check("t7_count", 80'(log_q.size() - s), 80'(12));
        check("t7_nlast", 80'(nlast - l), 80'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning pixels per image row (≥3).
REQ-002 SHALL have parameter IMG_H, default 28, meaning rows per frame (≥3).
REQ-003 SHALL have parameter DATA_W, default 8, meaning signed pixel width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  pixel present on in_data.
REQ-007 in_data  input  DATA_W signed  raster-order pixel.
REQ-008 in_ready  output  1  block accepts pixel this cycle.
REQ-009 out_valid  output  1  window on win0..win8 is valid.
REQ-010 out_ready  input  1  downstream dot-product stage consumes the window.
REQ-011 win0..win8  output  DATA_W signed each  3x3 window, row-major: win0 = (r-2,c-2), win8 = (r,c).
REQ-012 out_last  output  1  marks final window of a frame; qualified by out_valid.

Function
REQ-013 Pixel accepted iff in_valid && in_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready (single-entry output stage, no combinational path from in_valid).
REQ-015 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance on each accepted pixel only; col wraps to 0 and increments row; at (IMG_H-1, IMG_W-1) both wrap to 0 (next frame starts with no gap).
REQ-016 Two line buffers of depth IMG_W SHALL hold rows r-1 and r-2; each accepted pixel is written to LB0 at col, and LB0's prior content at col moves to LB1 at col.
REQ-017 A 3x3 window register SHALL shift one column left per accepted pixel; new right column = {LB1[col], LB0[col], in_data}.
REQ-018 Valid-convolution only (no padding): accepted pixel at (row,col) with row ≥ 2 and col ≥ 2 SHALL produce a window; other pixels produce none.
REQ-019 Produced window SHALL appear on win0..win8 with out_valid = 1 in the cycle after acceptance (latency 1).
REQ-020 out_valid SHALL stay high and win0..win8/out_last SHALL stay stable until out_valid && out_ready.
REQ-021 On consume with no new producing pixel in the same cycle, out_valid SHALL drop next cycle; consume and new producing pixel in the same cycle SHALL load the new window with out_valid kept high.
REQ-022 out_last SHALL be 1 exactly for the window from pixel (IMG_H-1, IMG_W-1).
REQ-023 Windows per frame SHALL be (IMG_W-2)*(IMG_H-2); gaps in in_valid SHALL not alter window contents.
REQ-024 Line-buffer contents across row wrap and frame boundary need no clearing; REQ-018 guards stale columns/rows.

Reset
REQ-025 When rst = 1 at a clock edge: col, row = 0; out_valid = 0; out_last = 0; win0..win8 = 0; in_ready therefore 1 after reset.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first pixel after reset is (0,0) of a new frame.
REQ-027 Line-buffer storage need not be reset.

Structure
REQ-028 Shared package SHALL hold DATA_W default and window index constants (WIN_TL=0 .. WIN_BR=8).
REQ-029 One sub-module line_buffer (parameters DEPTH, DATA_W; write-enable, address, write data, read data of the same address) SHALL be instantiated twice.
REQ-030 Counters, window shift register and output handshake SHALL reside in window_gen_3x3.

Verification (IMG_W=4, IMG_H=4, pixels 0..15 unless stated)
REQ-031 Stream 0..15 continuously, out_ready=1 -> 4 windows; first = {0,1,2,4,5,6,8,9,10} one cycle after pixel 10 accepted; last = {5,6,7,9,10,11,13,14,15} with out_last=1; no others.
REQ-032 Same stream, out_ready=0 from pixel 10 for 5 cycles -> in_ready=0, window {0,1,2,4,5,6,8,9,10} held stable; after release all 4 windows delivered in order, none lost or duplicated.
REQ-033 Random in_valid gaps (50%) -> identical 4 windows as REQ-031.
REQ-034 Two frames back-to-back (0..15 then 100..115) -> second frame first window {100,101,102,104,105,106,108,109,110}; out_last once per frame.
REQ-035 rst asserted after pixel 9, then stream 0..15 -> no window output before new pixel 10; then exactly REQ-031 sequence.
REQ-036 Signed extremes: pixels alternating -128/127 -> windows match raster model bit-exactly.
